// File: rtl/rl_fifo_pkg.sv
// Shared types and helpers for the first-word-fall-through FIFO and its RAM wrapper.
package rl_fifo_pkg;

  // Occupancy counters need one extra bit so that "completely full" is representable.
  function automatic int occ_width(input int abits);
    return abits + 1;
  endfunction

  typedef logic [1:0] buf_occ_t;

  localparam buf_occ_t BUF_EMPTY = 2'd0;
  localparam buf_occ_t BUF_FULL  = 2'd2;

endpackage

// File: rtl/rl_ram_1r1w.sv
// Generic 1R1W RAM wrapper: byte-enabled write port, registered read port (1-cycle latency).
module rl_ram_1r1w #(
  parameter int ABITS = 4,
  parameter int DBITS = 8,
  parameter int BEW   = (DBITS + 7) / 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             we,
  input  logic [ABITS-1:0] waddr,
  input  logic [DBITS-1:0] wdata,
  input  logic [BEW-1:0]   be,
  input  logic             re,
  input  logic [ABITS-1:0] raddr,
  output logic [DBITS-1:0] rdata
);

  logic [DBITS-1:0] mem [2**ABITS];

  // Behavioural array; technology macros replace this body when a target library is selected.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < DBITS; i++) begin
        if (be[i/8]) mem[waddr][i] <= wdata[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/rl_fifo_1r1w_fwft.sv
// FWFT FIFO on a 1R1W RAM; a 2-entry head/skid buffer hides the RAM read latency.
module rl_fifo_1r1w_fwft
  import rl_fifo_pkg::*;
#(
  parameter int ABITS    = 4,
  parameter int DBITS    = 8,
  parameter int AF_LEVEL = 2**ABITS - 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [DBITS-1:0] wr_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [DBITS-1:0] rd_data,
  output logic [ABITS:0]   count,
  output logic             empty,
  output logic             full,
  output logic             almost_full
);

  localparam int CW = occ_width(ABITS);
  localparam logic [CW-1:0] DEPTH_C = CW'(2**ABITS);

  logic [ABITS-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]    ram_cnt_q, ram_cnt_d;
  logic             inflight_q, inflight_d;
  buf_occ_t         occ_q, occ_d, occ_after_pop;
  logic [DBITS-1:0] head_q, head_d, skid_q, skid_d;
  logic [DBITS-1:0] ram_dout;
  logic             push, pop, we, re;
  logic [2:0]       rd_demand;

  assign count       = ram_cnt_q + CW'(inflight_q) + CW'(occ_q);
  assign wr_ready    = (count < DEPTH_C);
  assign rd_valid    = (occ_q != BUF_EMPTY);
  assign rd_data     = head_q;
  assign empty       = (count == '0);
  assign full        = (count == DEPTH_C);
  assign almost_full = (count >= CW'(AF_LEVEL));

  // clr suppresses both handshakes and any new RAM traffic in its cycle.
  assign push      = wr_valid & wr_ready & ~clr;
  assign pop       = rd_valid & rd_ready & ~clr;
  assign rd_demand = 3'(occ_q) + 3'(inflight_q) - 3'(pop);
  assign re        = (ram_cnt_q != '0) & (rd_demand < 3'(BUF_FULL)) & ~clr;
  assign we        = push;

  rl_ram_1r1w #(
    .ABITS(ABITS),
    .DBITS(DBITS)
  ) u_ram (
    .clk  (clk),
    .rstn (1'b1),
    .we   (we),
    .waddr(wptr_q),
    .wdata(wr_data),
    .be   ('1),
    .re   (re),
    .raddr(rptr_q),
    .rdata(ram_dout)
  );

  always_comb begin
    wptr_d        = wptr_q;
    rptr_d        = rptr_q;
    ram_cnt_d     = ram_cnt_q;
    inflight_d    = inflight_q;
    occ_d         = occ_q;
    head_d        = head_q;
    skid_d        = skid_q;
    occ_after_pop = occ_q - buf_occ_t'(pop);
    if (clr) begin
      wptr_d     = '0;
      rptr_d     = '0;
      ram_cnt_d  = '0;
      inflight_d = 1'b0;
      occ_d      = BUF_EMPTY;
      head_d     = '0;
      skid_d     = '0;
    end else begin
      wptr_d     = wptr_q + ABITS'(push);
      rptr_d     = rptr_q + ABITS'(re);
      ram_cnt_d  = ram_cnt_q + CW'(push) - CW'(re);
      inflight_d = re;
      if (pop) head_d = skid_q;
      // Returning RAM word lands in whichever slot is free once this cycle's pop is applied.
      if (inflight_q) begin
        if (occ_after_pop == BUF_EMPTY) head_d = ram_dout;
        else                            skid_d = ram_dout;
        occ_d = occ_after_pop + 2'd1;
      end else begin
        occ_d = occ_after_pop;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      ram_cnt_q  <= '0;
      inflight_q <= 1'b0;
      occ_q      <= BUF_EMPTY;
      head_q     <= '0;
      skid_q     <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      ram_cnt_q  <= ram_cnt_d;
      inflight_q <= inflight_d;
      occ_q      <= occ_d;
      head_q     <= head_d;
      skid_q     <= skid_d;
    end
  end

  a_no_addr_collision: assert property (@(posedge clk) disable iff (rst)
    !(we && re && (wptr_q == rptr_q)));

endmodule

// File: tb/tb_rl_fifo_1r1w_fwft.sv
// Directed and scoreboarded checks for rl_fifo_1r1w_fwft (ABITS=4, DBITS=8).
module tb_rl_fifo_1r1w_fwft;

  localparam int ABITS = 4;
  localparam int DBITS = 8;
  localparam int DEPTH = 16;

  logic             clk = 1'b0;
  logic             rst, clr, wr_valid, wr_ready, rd_valid, rd_ready;
  logic             empty, full, almost_full;
  logic [DBITS-1:0] wr_data, rd_data;
  logic [ABITS:0]   count;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  rl_fifo_1r1w_fwft #(.ABITS(ABITS), .DBITS(DBITS)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .count(count), .empty(empty), .full(full), .almost_full(almost_full)
  );

  // Packed view {rd_valid, rd_data, count, empty, full, almost_full, wr_ready} used for reset checks.
  task automatic test_reset();
    logic [17:0] got, want;
    want = {1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1};
    @(negedge clk);
    wr_valid = 1'b1;
    wr_data  = 8'h55;
    repeat (4) @(negedge clk);
    wr_valid = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({rd_valid, count} !== {1'b1, 5'd4}) begin
      tests_failed++;
      $display("[TB] FAIL reset_preload: got rd_valid=%b count=%0d, want 1/4", rd_valid, count);
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    got = {rd_valid, rd_data, count, empty, full, almost_full, wr_ready};
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("[TB] FAIL reset_async: got %h, want %h", got, want);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    got = {rd_valid, rd_data, count, empty, full, almost_full, wr_ready};
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("[TB] FAIL reset_release: got %h, want %h", got, want);
    end
  endtask

  task automatic test_fill();
    logic [7:0] got, want;
    int n, cyc;
    rd_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      want = {5'(i), (i >= 14), 1'b0, 1'b1};
      got  = {count, almost_full, full, wr_ready};
      tests_run++;
      if (got !== want) begin
        tests_failed++;
        $display("[TB] FAIL fill_flags_%0d: got %h, want %h", i, got, want);
      end
      wr_valid = 1'b1;
      wr_data  = 8'(i);
      @(negedge clk);
    end
    wr_data = 8'hFF;
    want = {5'd16, 1'b1, 1'b1, 1'b0};
    got  = {count, almost_full, full, wr_ready};
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("[TB] FAIL fill_full: got %h, want %h", got, want);
    end
    @(negedge clk);
    tests_run++;
    if ({count, wr_ready} !== {5'd16, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL fill_stall: got count=%0d wr_ready=%b, want 16/0", count, wr_ready);
    end
    // Push and pop together at full: only the pop may take effect.
    rd_ready = 1'b1;
    tests_run++;
    if ({rd_valid, rd_data} !== {1'b1, 8'h00}) begin
      tests_failed++;
      $display("[TB] FAIL fill_head: got valid=%b data=%h, want 1/00", rd_valid, rd_data);
    end
    @(negedge clk);
    wr_valid = 1'b0;
    tests_run++;
    if (count !== 5'd15) begin
      tests_failed++;
      $display("[TB] FAIL full_push_pop: got count=%0d, want 15", count);
    end
    n = 1;
    cyc = 0;
    while (n < DEPTH && cyc < 100) begin
      if (rd_valid) begin
        tests_run++;
        if (rd_data !== 8'(n)) begin
          tests_failed++;
          $display("[TB] FAIL drain_data_%0d: got %h, want %h", n, rd_data, 8'(n));
        end
        n++;
      end
      @(negedge clk);
      cyc++;
    end
    tests_run++;
    if (n != DEPTH) begin
      tests_failed++;
      $display("[TB] FAIL drain_timeout: got %0d words, want %0d", n, DEPTH);
    end
    repeat (3) @(negedge clk);
    tests_run++;
    if ({rd_valid, empty, count} !== {1'b0, 1'b1, 5'd0}) begin
      tests_failed++;
      $display("[TB] FAIL drain_empty: got valid=%b empty=%b count=%0d, want 0/1/0", rd_valid, empty, count);
    end
    rd_ready = 1'b0;
  endtask

  task automatic test_latency();
    int cyc;
    wr_valid = 1'b1;
    wr_data  = 8'hA5;
    @(negedge clk);
    wr_valid = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      tests_run++;
      if (rd_valid !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL latency_early_c%0d: got rd_valid=%b, want 0", c, rd_valid);
      end
      @(negedge clk);
    end
    tests_run++;
    if ({rd_valid, rd_data, count} !== {1'b1, 8'hA5, 5'd1}) begin
      tests_failed++;
      $display("[TB] FAIL latency_c3: got valid=%b data=%h count=%0d, want 1/a5/1", rd_valid, rd_data, count);
    end
    // Simultaneous push and pop at count 1 keeps the count at 1.
    rd_ready = 1'b1;
    wr_valid = 1'b1;
    wr_data  = 8'h5A;
    @(negedge clk);
    rd_ready = 1'b0;
    wr_valid = 1'b0;
    tests_run++;
    if ({count, empty} !== {5'd1, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL count1_push_pop: got count=%0d empty=%b, want 1/0", count, empty);
    end
    cyc = 0;
    while (!rd_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    tests_run++;
    if ({rd_valid, rd_data} !== {1'b1, 8'h5A}) begin
      tests_failed++;
      $display("[TB] FAIL count1_data: got valid=%b data=%h, want 1/5a", rd_valid, rd_data);
    end
    rd_ready = 1'b1;
    @(negedge clk);
    rd_ready = 1'b0;
    tests_run++;
    if ({rd_valid, empty, count} !== {1'b0, 1'b1, 5'd0}) begin
      tests_failed++;
      $display("[TB] FAIL latency_empty: got valid=%b empty=%b count=%0d, want 0/1/0", rd_valid, empty, count);
    end
  endtask

  task automatic test_back_to_back();
    int sent, recv, first, gaps;
    sent = 0;
    recv = 0;
    first = -1;
    gaps = 0;
    rd_ready = 1'b1;
    for (int cyc = 0; cyc < 400 && recv < 200; cyc++) begin
      if (rd_valid) begin
        tests_run++;
        if (rd_data !== 8'(recv)) begin
          tests_failed++;
          $display("[TB] FAIL stream_data_%0d: got %h, want %h", recv, rd_data, 8'(recv));
        end
        if (first < 0) first = cyc;
        recv++;
      end else if (first >= 0) begin
        gaps++;
      end
      wr_valid = (sent < 200);
      wr_data  = 8'(sent);
      if (wr_valid && wr_ready) sent++;
      @(negedge clk);
    end
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    tests_run++;
    if ({first, recv, gaps} !== {32'sd3, 32'sd200, 32'sd0}) begin
      tests_failed++;
      $display("[TB] FAIL stream_rate: got first=%0d recv=%0d gaps=%0d, want 3/200/0", first, recv, gaps);
    end
    tests_run++;
    if ({empty, count} !== {1'b1, 5'd0}) begin
      tests_failed++;
      $display("[TB] FAIL stream_empty: got empty=%b count=%0d, want 1/0", empty, count);
    end
  endtask

  task automatic test_random();
    logic [7:0] q[$];
    int model_count, cyc;
    logic do_push, do_pop, prev_stall;
    logic [7:0] prev_data;
    model_count = 0;
    prev_stall  = 1'b0;
    prev_data   = '0;
    for (int c = 0; c < 2000; c++) begin
      tests_run++;
      if ({count, wr_ready} !== {5'(model_count), (model_count < DEPTH)}) begin
        tests_failed++;
        $display("[TB] FAIL rand_count_c%0d: got count=%0d wr_ready=%b, want %0d", c, count, wr_ready, model_count);
      end
      if (rd_valid) begin
        tests_run++;
        if (q.size() == 0 || rd_data !== q[0]) begin
          tests_failed++;
          $display("[TB] FAIL rand_data_c%0d: got %h, want %h (model size %0d)", c, rd_data, (q.size() > 0) ? q[0] : 8'h00, q.size());
        end
      end
      if (prev_stall) begin
        tests_run++;
        if ({rd_valid, rd_data} !== {1'b1, prev_data}) begin
          tests_failed++;
          $display("[TB] FAIL rand_stable_c%0d: got valid=%b data=%h, want 1/%h", c, rd_valid, rd_data, prev_data);
        end
      end
      wr_valid = 1'($urandom_range(0, 1));
      wr_data  = 8'($urandom);
      rd_ready = 1'($urandom_range(0, 1));
      do_push = wr_valid && (model_count < DEPTH);
      do_pop  = rd_valid && rd_ready;
      prev_stall = rd_valid && !rd_ready;
      prev_data  = rd_data;
      @(posedge clk);
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(wr_data);
      model_count = model_count + int'(do_push) - int'(do_pop);
      @(negedge clk);
    end
    wr_valid = 1'b0;
    rd_ready = 1'b1;
    cyc = 0;
    while (q.size() > 0 && cyc < 100) begin
      if (rd_valid) begin
        tests_run++;
        if (rd_data !== q[0]) begin
          tests_failed++;
          $display("[TB] FAIL rand_drain_data: got %h, want %h", rd_data, q[0]);
        end
        void'(q.pop_front());
      end
      @(negedge clk);
      cyc++;
    end
    rd_ready = 1'b0;
    tests_run++;
    if (q.size() != 0 || {empty, rd_valid} !== {1'b1, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL rand_drain_end: got left=%0d empty=%b valid=%b, want 0/1/0", q.size(), empty, rd_valid);
    end
  endtask

  task automatic test_clear();
    int cyc;
    rd_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'(8'h10 + i);
      @(negedge clk);
    end
    wr_valid = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({count, rd_valid, rd_data} !== {5'd5, 1'b1, 8'h10}) begin
      tests_failed++;
      $display("[TB] FAIL clr_setup: got count=%0d valid=%b data=%h, want 5/1/10", count, rd_valid, rd_data);
    end
    // This pop frees a buffer slot and launches a RAM read for the third word.
    rd_ready = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({count, rd_data} !== {5'd4, 8'h11}) begin
      tests_failed++;
      $display("[TB] FAIL clr_pre_pop: got count=%0d data=%h, want 4/11", count, rd_data);
    end
    clr      = 1'b1;
    wr_valid = 1'b1;
    wr_data  = 8'hEE;
    @(negedge clk);
    clr      = 1'b0;
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    tests_run++;
    if ({count, rd_valid, empty} !== {5'd0, 1'b0, 1'b1}) begin
      tests_failed++;
      $display("[TB] FAIL clr_flush: got count=%0d valid=%b empty=%b, want 0/0/1", count, rd_valid, empty);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      tests_run++;
      if ({count, rd_valid} !== {5'd0, 1'b0}) begin
        tests_failed++;
        $display("[TB] FAIL clr_ghost_c%0d: got count=%0d valid=%b data=%h, want 0/0", c, count, rd_valid, rd_data);
      end
    end
    wr_valid = 1'b1;
    wr_data  = 8'h3C;
    @(negedge clk);
    wr_valid = 1'b0;
    cyc = 0;
    while (!rd_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    tests_run++;
    if ({rd_valid, rd_data, count} !== {1'b1, 8'h3C, 5'd1}) begin
      tests_failed++;
      $display("[TB] FAIL clr_reuse: got valid=%b data=%h count=%0d, want 1/3c/1", rd_valid, rd_data, count);
    end
    rd_ready = 1'b1;
    @(negedge clk);
    rd_ready = 1'b0;
    tests_run++;
    if ({empty, rd_valid} !== {1'b1, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL clr_reuse_empty: got empty=%b valid=%b, want 1/0", empty, rd_valid);
    end
  endtask

  initial begin
    rst      = 1'b0;
    clr      = 1'b0;
    wr_valid = 1'b0;
    wr_data  = '0;
    rd_ready = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_fill();
    test_latency();
    test_back_to_back();
    test_random();
    test_clear();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
